// File: rtl/main_pkg.sv
// Shared definitions for the five-stage MIPS32-subset core: opcodes,
// instruction fields, instruction classes and the ID/EX pipeline record.
package main_pkg;

    // Memory geometry (word addressed)
    localparam int unsigned MEM_DEPTH = 32'd1024;
    localparam int unsigned MEM_AW    = 32'd10;
    localparam int unsigned NUM_REGS  = 32'd32;

    // Instruction field positions
    localparam int unsigned OPC_MSB = 32'd31;
    localparam int unsigned OPC_LSB = 32'd26;
    localparam int unsigned RS_MSB  = 32'd25;
    localparam int unsigned RS_LSB  = 32'd21;
    localparam int unsigned RT_MSB  = 32'd20;
    localparam int unsigned RT_LSB  = 32'd16;
    localparam int unsigned RD_MSB  = 32'd15;
    localparam int unsigned RD_LSB  = 32'd11;
    localparam int unsigned IMM_MSB = 32'd15;
    localparam int unsigned IMM_LSB = 32'd0;

    // Opcodes
    localparam logic [5:0] OP_ADD   = 6'd0;
    localparam logic [5:0] OP_SUB   = 6'd1;
    localparam logic [5:0] OP_AND   = 6'd2;
    localparam logic [5:0] OP_OR    = 6'd3;
    localparam logic [5:0] OP_SLT   = 6'd4;
    localparam logic [5:0] OP_MUL   = 6'd5;
    localparam logic [5:0] OP_LW    = 6'd8;
    localparam logic [5:0] OP_SW    = 6'd9;
    localparam logic [5:0] OP_ADDI  = 6'd10;
    localparam logic [5:0] OP_SUBI  = 6'd11;
    localparam logic [5:0] OP_SLTI  = 6'd12;
    localparam logic [5:0] OP_BNEQZ = 6'd13;
    localparam logic [5:0] OP_BEQZ  = 6'd14;
    localparam logic [5:0] OP_HLT   = 6'd63;

    typedef enum logic [2:0] {
        RR_ALU = 3'd0,
        RM_ALU = 3'd1,
        LOAD   = 3'd2,
        STORE  = 3'd3,
        BRANCH = 3'd4,
        HALT   = 3'd5,
        NOP    = 3'd6
    } instr_class_t;

    // Decoded instruction as carried from ID to EX. dest is 0 for
    // instructions that write no register, which also discards R0 writes.
    typedef struct packed {
        instr_class_t cls;
        logic [5:0]   opc;
        logic [4:0]   rs;
        logic [4:0]   rt;
        logic [4:0]   dest;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [31:0]  imm;
        logic [31:0]  npc;
    } id_ex_t;

    function automatic instr_class_t decode_class(input logic [5:0] opcode);
        instr_class_t cls;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: cls = RR_ALU;
            OP_ADDI, OP_SUBI, OP_SLTI:                     cls = RM_ALU;
            OP_LW:                                         cls = LOAD;
            OP_SW:                                         cls = STORE;
            OP_BNEQZ, OP_BEQZ:                             cls = BRANCH;
            OP_HLT:                                        cls = HALT;
            default:                                       cls = NOP;
        endcase
        return cls;
    endfunction

    function automatic logic [31:0] sign_ext(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic id_ex_t id_ex_bubble();
        id_ex_t b;
        b     = '0;
        b.cls = NOP;
        return b;
    endfunction

endpackage

// File: rtl/main_alu.sv
// Combinational ALU: register/immediate arithmetic, compares, multiply and
// effective-address add (any opcode without its own operation adds).
module main_alu
    import main_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);

    // Select the operation for the opcode; loads, stores and others add
    always_comb begin
        result = a + b;
        case (opcode)
            OP_ADD, OP_ADDI, OP_LW, OP_SW: result = a + b;
            OP_SUB, OP_SUBI:               result = a - b;
            OP_AND:                        result = a & b;
            OP_OR:                         result = a | b;
            OP_SLT, OP_SLTI:               result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_MUL:                        result = a * b;
            default:                       result = a + b;
        endcase
    end

endmodule

// File: rtl/main.sv
// Five-stage pipelined MIPS32-subset core with unified word-addressed
// memory, forwarding, load-use stall, EX-resolved branches and halt.
module main
    import main_pkg::*;
(
    input  logic clk1,
    input  logic rst_n,
    output logic halted
);

    // Architectural state, visible through hierarchy
    logic [31:0] Memory   [0:MEM_DEPTH-1];
    logic [31:0] Register [0:NUM_REGS-1];
    logic [31:0] PC;
    logic        HALTED;
    logic        TAKEN_BRANCH;

    // IF/ID
    logic         if_id_valid_r;
    logic [31:0]  if_id_ir_r;
    logic [31:0]  if_id_npc_r;
    // ID/EX
    id_ex_t       id_ex_r;
    // EX/MEM
    instr_class_t ex_mem_cls_r;
    logic [4:0]   ex_mem_dest_r;
    logic [31:0]  ex_mem_alu_r;
    logic [31:0]  ex_mem_b_r;
    // MEM/WB
    instr_class_t mem_wb_cls_r;
    logic [4:0]   mem_wb_dest_r;
    logic [31:0]  mem_wb_result_r;

    // Combinational stage signals
    logic [31:0]  if_instr_s;
    logic [5:0]   id_opc_s;
    logic [4:0]   id_rs_s;
    logic [4:0]   id_rt_s;
    logic [4:0]   id_rd_s;
    instr_class_t id_cls_s;
    logic         id_use_rs_s;
    logic         id_use_rt_s;
    id_ex_t       id_dec_s;
    logic         load_use_stall_s;
    logic [31:0]  ex_a_s;
    logic [31:0]  ex_b_s;
    logic [31:0]  ex_opb_s;
    logic [31:0]  ex_alu_s;
    logic         branch_taken_s;
    logic [31:0]  branch_target_s;
    logic [31:0]  mem_rdata_s;

    assign halted      = HALTED;
    assign if_instr_s  = Memory[PC[MEM_AW-1:0]];
    assign mem_rdata_s = Memory[ex_mem_alu_r[MEM_AW-1:0]];

    // Decode IF/ID, read registers with write-through from WB, detect load-use
    always_comb begin
        id_opc_s    = if_id_ir_r[OPC_MSB:OPC_LSB];
        id_rs_s     = if_id_ir_r[RS_MSB:RS_LSB];
        id_rt_s     = if_id_ir_r[RT_MSB:RT_LSB];
        id_rd_s     = if_id_ir_r[RD_MSB:RD_LSB];
        id_cls_s    = if_id_valid_r ? decode_class(id_opc_s) : NOP;
        id_use_rs_s = 1'b0;
        id_use_rt_s = 1'b0;
        id_dec_s    = id_ex_bubble();
        case (id_cls_s)
            RR_ALU: begin
                id_dec_s.dest = id_rd_s;
                id_use_rs_s   = 1'b1;
                id_use_rt_s   = 1'b1;
            end
            RM_ALU, LOAD: begin
                id_dec_s.dest = id_rt_s;
                id_use_rs_s   = 1'b1;
            end
            STORE: begin
                id_use_rs_s = 1'b1;
                id_use_rt_s = 1'b1;
            end
            BRANCH: begin
                id_use_rs_s = 1'b1;
            end
            default: begin
                id_use_rs_s = 1'b0;
            end
        endcase
        id_dec_s.cls = id_cls_s;
        id_dec_s.opc = id_opc_s;
        id_dec_s.rs  = id_rs_s;
        id_dec_s.rt  = id_rt_s;
        id_dec_s.imm = sign_ext(if_id_ir_r[IMM_MSB:IMM_LSB]);
        id_dec_s.npc = if_id_npc_r;
        if (id_rs_s == 5'd0) begin
            id_dec_s.a = 32'd0;
        end else if (id_rs_s == mem_wb_dest_r) begin
            id_dec_s.a = mem_wb_result_r;
        end else begin
            id_dec_s.a = Register[id_rs_s];
        end
        if (id_rt_s == 5'd0) begin
            id_dec_s.b = 32'd0;
        end else if (id_rt_s == mem_wb_dest_r) begin
            id_dec_s.b = mem_wb_result_r;
        end else begin
            id_dec_s.b = Register[id_rt_s];
        end
        if (id_ex_r.cls == LOAD && id_ex_r.dest != 5'd0) begin
            load_use_stall_s = (id_use_rs_s && (id_rs_s == id_ex_r.dest)) ||
                               (id_use_rt_s && (id_rt_s == id_ex_r.dest));
        end else begin
            load_use_stall_s = 1'b0;
        end
    end

    // Forward EX operands (EX/MEM ALU result before MEM/WB) and resolve branches
    always_comb begin
        if (ex_mem_dest_r != 5'd0 && ex_mem_cls_r != LOAD && ex_mem_dest_r == id_ex_r.rs) begin
            ex_a_s = ex_mem_alu_r;
        end else if (mem_wb_dest_r != 5'd0 && mem_wb_dest_r == id_ex_r.rs) begin
            ex_a_s = mem_wb_result_r;
        end else begin
            ex_a_s = id_ex_r.a;
        end
        if (ex_mem_dest_r != 5'd0 && ex_mem_cls_r != LOAD && ex_mem_dest_r == id_ex_r.rt) begin
            ex_b_s = ex_mem_alu_r;
        end else if (mem_wb_dest_r != 5'd0 && mem_wb_dest_r == id_ex_r.rt) begin
            ex_b_s = mem_wb_result_r;
        end else begin
            ex_b_s = id_ex_r.b;
        end
        ex_opb_s = (id_ex_r.cls == RR_ALU) ? ex_b_s : id_ex_r.imm;
        if (id_ex_r.cls == BRANCH) begin
            if (id_ex_r.opc == OP_BEQZ) begin
                branch_taken_s = (ex_a_s == 32'd0);
            end else begin
                branch_taken_s = (ex_a_s != 32'd0);
            end
        end else begin
            branch_taken_s = 1'b0;
        end
        branch_target_s = id_ex_r.npc + id_ex_r.imm;
    end

    main_alu u_alu (
        .opcode (id_ex_r.opc),
        .a      (ex_a_s),
        .b      (ex_opb_s),
        .result (ex_alu_s)
    );

    // Front end: PC, IF/ID and ID/EX with branch flush, load-use stall and halt hold.
    // A HLT sitting in IF/ID keeps PC and IF/ID frozen; only a taken branch
    // can remove it, after which fetch resumes at the target.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            PC            <= 32'd0;
            if_id_valid_r <= 1'b0;
            if_id_ir_r    <= 32'd0;
            if_id_npc_r   <= 32'd0;
            id_ex_r       <= id_ex_bubble();
        end else if (!HALTED) begin
            if (branch_taken_s) begin
                PC            <= branch_target_s;
                if_id_valid_r <= 1'b0;
                id_ex_r       <= id_ex_bubble();
            end else if (load_use_stall_s) begin
                id_ex_r <= id_ex_bubble();
            end else begin
                id_ex_r <= id_dec_s;
                if (id_cls_s != HALT) begin
                    PC            <= PC + 32'd1;
                    if_id_valid_r <= 1'b1;
                    if_id_ir_r    <= if_instr_s;
                    if_id_npc_r   <= PC + 32'd1;
                end
            end
        end
    end

    // Back end: EX/MEM and MEM/WB registers, branch indicator and halt flag
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            ex_mem_cls_r    <= NOP;
            ex_mem_dest_r   <= 5'd0;
            ex_mem_alu_r    <= 32'd0;
            ex_mem_b_r      <= 32'd0;
            mem_wb_cls_r    <= NOP;
            mem_wb_dest_r   <= 5'd0;
            mem_wb_result_r <= 32'd0;
            TAKEN_BRANCH    <= 1'b0;
            HALTED          <= 1'b0;
        end else if (!HALTED) begin
            ex_mem_cls_r    <= id_ex_r.cls;
            ex_mem_dest_r   <= id_ex_r.dest;
            ex_mem_alu_r    <= ex_alu_s;
            ex_mem_b_r      <= ex_b_s;
            mem_wb_cls_r    <= ex_mem_cls_r;
            mem_wb_dest_r   <= ex_mem_dest_r;
            mem_wb_result_r <= (ex_mem_cls_r == LOAD) ? mem_rdata_s : ex_mem_alu_r;
            TAKEN_BRANCH    <= branch_taken_s;
            HALTED          <= (mem_wb_cls_r == HALT);
        end
    end

    // Register file write-back; dest 0 means no write, so R0 stays zero
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32'sd32; i++) begin
                Register[i[4:0]] <= 32'd0;
            end
        end else if (!HALTED && mem_wb_dest_r != 5'd0) begin
            Register[mem_wb_dest_r] <= mem_wb_result_r;
        end
    end

    // Store commit in MEM; memory has no reset so preloaded contents survive
    always_ff @(posedge clk1) begin
        if (!HALTED && ex_mem_cls_r == STORE) begin
            Memory[ex_mem_alu_r[MEM_AW-1:0]] <= ex_mem_b_r;
        end
    end

endmodule

// File: tb/tb_main.sv
// Scoreboard bench for the pipelined core: programs are preloaded through
// hierarchy, expected state is queued at setup and compared after halt.
module tb_main;
    import main_pkg::*;

    logic clk1  = 1'b0;
    logic rst_n = 1'b1;
    logic halted;

    int n_checks = 0;
    int n_errors = 0;
    bit trace_en = 1'b0;

    logic [31:0] prog_q[$];
    string       sb_tag_q[$];
    int          sb_kind_q[$];
    int          sb_idx_q[$];
    logic [31:0] sb_val_q[$];
    logic [31:0] r2_trace_q[$];

    main dut (
        .clk1   (clk1),
        .rst_n  (rst_n),
        .halted (halted)
    );

    always #5 clk1 = ~clk1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs, input int rt);
        return {op, rs[4:0], rt[4:0], rd[4:0], 11'd0};
    endfunction

    function automatic logic [31:0] ri(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] hlt();
        return {OP_HLT, 26'd0};
    endfunction

    function automatic logic [31:0] fact(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 2; i <= n; i++) p = p * 32'(i);
        return p;
    endfunction

    // kind: 0 = memory word, 1 = register, 2 = PC
    task automatic expect_state(input string tag, input int kind, input int idx, input logic [31:0] val);
        sb_tag_q.push_back(tag);
        sb_kind_q.push_back(kind);
        sb_idx_q.push_back(idx);
        sb_val_q.push_back(val);
    endtask

    task automatic drain_scoreboard();
        logic [31:0] obs;
        int k;
        int idx;
        while (sb_kind_q.size() > 0) begin
            k   = sb_kind_q.pop_front();
            idx = sb_idx_q.pop_front();
            case (k)
                0:       obs = dut.Memory[idx];
                1:       obs = dut.Register[idx];
                default: obs = dut.PC;
            endcase
            check_eq(sb_tag_q.pop_front(), obs, sb_val_q.pop_front());
        end
    endtask

    task automatic assert_reset();
        @(negedge clk1);
        rst_n = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk1);
        rst_n = 1'b1;
    endtask

    task automatic load_program();
        for (int i = 0; i < 1024; i++) dut.Memory[i] = 32'd0;
        for (int i = 0; i < prog_q.size(); i++) dut.Memory[i] = prog_q[i];
    endtask

    task automatic build_fact(input bit padded);
        int off;
        off = padded ? -4 : -3;
        prog_q.delete();
        prog_q.push_back(ri(OP_ADDI, 10, 0, 200));
        prog_q.push_back(ri(OP_ADDI, 2, 0, 1));
        prog_q.push_back(ri(OP_LW, 3, 10, 0));
        prog_q.push_back(rr(OP_MUL, 2, 2, 3));
        if (padded) prog_q.push_back(rr(OP_OR, 20, 20, 20));
        prog_q.push_back(ri(OP_SUBI, 3, 3, 1));
        prog_q.push_back(ri(OP_BNEQZ, 0, 3, off));
        prog_q.push_back(ri(OP_SW, 2, 10, -2));
        prog_q.push_back(hlt());
    endtask

    // Clock until halted (bounded); cycles counts edges since reset release
    task automatic run_to_halt(input string tag, input int budget, output int cycles, output int taken);
        logic [31:0] r2_last;
        bit done;
        r2_last = dut.Register[2];
        cycles  = 0;
        taken   = 0;
        done    = 1'b0;
        while (!done && cycles < budget) begin
            @(posedge clk1);
            #1;
            cycles++;
            if (dut.TAKEN_BRANCH) taken++;
            if (trace_en && dut.Register[2] !== r2_last) begin
                r2_last = dut.Register[2];
                if (r2_trace_q.size() == 0) check_eq({tag, "_r2_extra_write"}, 32'(r2_trace_q.size()), 32'd1);
                else check_eq({tag, "_r2_trace"}, r2_last, r2_trace_q.pop_front());
            end
            if (halted) done = 1'b1;
        end
        check_eq({tag, "_halted"}, {31'd0, halted}, 32'd1);
    endtask

    task automatic run_fact(input string tag, input bit padded, input int n);
        int cycles;
        int taken;
        int body;
        body = padded ? 4 : 3;
        assert_reset();
        build_fact(padded);
        load_program();
        dut.Memory[200] = 32'(n);
        expect_state({tag, "_mem198"}, 0, 198, fact(n));
        expect_state({tag, "_mem200"}, 0, 200, 32'(n));
        expect_state({tag, "_r2"}, 1, 2, fact(n));
        expect_state({tag, "_r3"}, 1, 3, 32'd0);
        expect_state({tag, "_r10"}, 1, 10, 32'd200);
        release_reset();
        run_to_halt(tag, 600, cycles, taken);
        check_eq({tag, "_cycles"}, 32'(cycles), 32'(3 + body * n + 1 + 5 + 1 + 2 * (n - 1)));
        check_eq({tag, "_taken"}, 32'(taken), 32'(n - 1));
        drain_scoreboard();
    endtask

    initial begin
        int cycles;
        int taken;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        build_fact(1'b1);
        load_program();
        expect_state("rst_pc", 2, 0, 32'd0);
        expect_state("rst_r2", 1, 2, 32'd0);
        expect_state("rst_r31", 1, 31, 32'd0);
        drain_scoreboard();
        check_eq("rst_halted", {31'd0, halted}, 32'd0);
        check_eq("rst_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);

        // Padded factorial of 5 with R2 history
        trace_en = 1'b1;
        r2_trace_q = '{32'd1, 32'd5, 32'd20, 32'd60, 32'd120};
        run_fact("fact5_pad", 1'b1, 5);
        check_eq("fact5_trace_len", 32'(r2_trace_q.size()), 32'd0);
        trace_en = 1'b0;

        // Unpadded factorials, including 32-bit wrap
        run_fact("fact12", 1'b0, 12);
        run_fact("fact13", 1'b0, 13);

        // Forwarding, load-use stall, R0 write, store after HLT, PC freeze
        assert_reset();
        prog_q.delete();
        prog_q.push_back(ri(OP_ADDI, 1, 0, 7));
        prog_q.push_back(rr(OP_ADD, 2, 1, 1));
        prog_q.push_back(ri(OP_LW, 4, 0, 300));
        prog_q.push_back(rr(OP_ADD, 5, 4, 0));
        prog_q.push_back(ri(OP_ADDI, 0, 0, 9));
        prog_q.push_back(hlt());
        prog_q.push_back(ri(OP_SW, 1, 0, 301));
        load_program();
        dut.Memory[300] = 32'd33;
        dut.Memory[301] = 32'd777;
        expect_state("haz_r1", 1, 1, 32'd7);
        expect_state("haz_fwd_r2", 1, 2, 32'd14);
        expect_state("haz_r4", 1, 4, 32'd33);
        expect_state("haz_loaduse_r5", 1, 5, 32'd33);
        expect_state("haz_r0", 1, 0, 32'd0);
        expect_state("haz_sw_after_hlt", 0, 301, 32'd777);
        release_reset();
        run_to_halt("haz", 200, cycles, taken);
        check_eq("haz_cycles", 32'(cycles), 32'd11);
        drain_scoreboard();
        repeat (10) @(posedge clk1);
        #1;
        expect_state("haz_pc_frozen", 2, 0, 32'd6);
        expect_state("haz_r2_frozen", 1, 2, 32'd14);
        drain_scoreboard();
        check_eq("haz_halted_held", {31'd0, halted}, 32'd1);

        // Taken branch skips two instructions
        assert_reset();
        prog_q.delete();
        prog_q.push_back(ri(OP_ADDI, 1, 0, 1));
        prog_q.push_back(ri(OP_BEQZ, 0, 0, 2));
        prog_q.push_back(ri(OP_ADDI, 6, 0, 66));
        prog_q.push_back(ri(OP_SW, 1, 0, 302));
        prog_q.push_back(ri(OP_ADDI, 7, 0, 77));
        prog_q.push_back(hlt());
        load_program();
        dut.Memory[302] = 32'd555;
        expect_state("br_r1", 1, 1, 32'd1);
        expect_state("br_skip_r6", 1, 6, 32'd0);
        expect_state("br_skip_mem", 0, 302, 32'd555);
        expect_state("br_target_r7", 1, 7, 32'd77);
        release_reset();
        run_to_halt("br", 200, cycles, taken);
        check_eq("br_cycles", 32'(cycles), 32'd10);
        check_eq("br_taken_pulse", 32'(taken), 32'd1);
        drain_scoreboard();

        // Reset in the middle of the factorial loop, then rerun
        assert_reset();
        build_fact(1'b1);
        load_program();
        dut.Memory[200] = 32'd5;
        release_reset();
        repeat (15) @(posedge clk1);
        assert_reset();
        check_eq("midrst_halted", {31'd0, halted}, 32'd0);
        check_eq("midrst_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);
        expect_state("midrst_pc", 2, 0, 32'd0);
        expect_state("midrst_r2", 1, 2, 32'd0);
        expect_state("midrst_r3", 1, 3, 32'd0);
        expect_state("midrst_r10", 1, 10, 32'd0);
        expect_state("midrst_mem200", 0, 200, 32'd5);
        expect_state("midrst_mem3", 0, 3, prog_q[3]);
        expect_state("midrst_mem198", 0, 198, 32'd0);
        drain_scoreboard();
        trace_en = 1'b1;
        r2_trace_q = '{32'd1, 32'd5, 32'd20, 32'd60, 32'd120};
        expect_state("rerun_mem198", 0, 198, 32'd120);
        expect_state("rerun_r2", 1, 2, 32'd120);
        release_reset();
        run_to_halt("rerun", 300, cycles, taken);
        check_eq("rerun_cycles", 32'(cycles), 32'd38);
        check_eq("rerun_trace_len", 32'(r2_trace_q.size()), 32'd0);
        trace_en = 1'b0;
        drain_scoreboard();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
